// File: rtl/dmac_chan_sched_if.sv
// Signal bundle between the DMAC channel scheduler (master) and the
// peripherals, AHB arbiter and channel datapath around it (slave).
interface dmac_chan_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();
  // Bus_Req acts as valid and Bus_Grant && HReady as ready: Bus_Req is held
  // until both are sampled high on one clock edge, which consumes the grant.
  logic [NUM_REQ-1:0] DmacReq;
  logic               Bus_Grant;
  logic               HReady;
  logic               Beat_Done;
  logic               Trans_Done;
  logic               Bus_Req;
  logic               Grant_Vld;
  logic [ID_W-1:0]    Grant_Id;
  logic [NUM_REQ-1:0] ReqAck;
  logic               Ch_Start;
  logic               Ch_Resume;
  logic               Ch_Pause;
  logic [NUM_REQ-1:0] Pending;
  logic [2:0]         dbg_state;

  modport master (
    input  DmacReq, Bus_Grant, HReady, Beat_Done, Trans_Done,
    output Bus_Req, Grant_Vld, Grant_Id, ReqAck, Ch_Start, Ch_Resume,
           Ch_Pause, Pending, dbg_state
  );

  modport slave (
    output DmacReq, Bus_Grant, HReady, Beat_Done, Trans_Done,
    input  Bus_Req, Grant_Vld, Grant_Id, ReqAck, Ch_Start, Ch_Resume,
           Ch_Pause, Pending, dbg_state
  );
endinterface

// File: rtl/dmac_chan_sched.sv
// DMAC channel scheduler: arbitration, bus handshake and beat time-slicing.
// Define DMAC_SCHED_RR_EN for round-robin selection (default: highest index wins).
module dmac_chan_sched #(
  parameter int NUM_REQ     = 4,
  parameter int SLICE_BEATS = 16,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  dmac_chan_sched_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUS_REQ = 3'd1,
    S_START   = 3'd2,
    S_ACTIVE  = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [7:0] SLICE = 8'(SLICE_BEATS);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    win_q, win_d, sel_id;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [7:0]         cnt_q, cnt_d, cnt_inc;
  logic [NUM_REQ-1:0] elig, win_oh, others;

  logic               bus_req, grant_vld, ch_start, ch_resume, pause;
  logic [NUM_REQ-1:0] req_ack;

  assign elig    = bus.DmacReq | pend_q;
  assign win_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;
  assign others  = elig & ~win_oh;
  assign cnt_inc = (cnt_q == SLICE) ? cnt_q : cnt_q + 8'd1;

`ifdef DMAC_SCHED_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Search upward from ptr+1; the pointer itself is the last candidate.
  always_comb begin
    int idx;
    idx    = 0;
    sel_id = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (elig[ID_W'(idx)]) sel_id = ID_W'(idx);
    end
  end

  assign ptr_d = (state_q == S_START) ? win_q : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    sel_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (elig[i]) sel_id = ID_W'(i);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    bus_req   = 1'b0;
    grant_vld = 1'b0;
    req_ack   = '0;
    ch_start  = 1'b0;
    ch_resume = 1'b0;
    pause     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|elig) begin
          win_d   = sel_id;
          state_d = S_BUS_REQ;
        end
      end
      S_BUS_REQ: begin
        bus_req = 1'b1;
        if (bus.Bus_Grant && bus.HReady) state_d = S_START;
      end
      S_START: begin
        bus_req   = 1'b1;
        grant_vld = 1'b1;
        req_ack   = win_oh;
        ch_start  = 1'b1;
        ch_resume = |(pend_q & win_oh);
        pend_d    = pend_q & ~win_oh;
        cnt_d     = '0;
        state_d   = S_ACTIVE;
      end
      S_ACTIVE: begin
        bus_req   = 1'b1;
        grant_vld = 1'b1;
        if (bus.Beat_Done) cnt_d = cnt_inc;
        // Completion beats arbiter preemption, which beats slice expiry.
        if (bus.Trans_Done) begin
          state_d = S_RELEASE;
        end else if (!bus.Bus_Grant) begin
          pause   = 1'b1;
          pend_d  = pend_q | win_oh;
          state_d = S_BUS_REQ;
        end else if (bus.Beat_Done && (cnt_inc == SLICE) && (|others)) begin
          pause   = 1'b1;
          pend_d  = pend_q | win_oh;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // A reset aborts the transfer outright, so never signal a pause during it.
  assign bus.Ch_Pause  = pause & ~rst;
  assign bus.Bus_Req   = bus_req;
  assign bus.Grant_Vld = grant_vld;
  assign bus.Grant_Id  = win_q;
  assign bus.ReqAck    = req_ack;
  assign bus.Ch_Start  = ch_start;
  assign bus.Ch_Resume = ch_resume;
  assign bus.Pending   = pend_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_dmac_chan_sched.sv
// Directed bench for dmac_chan_sched (NUM_REQ=4, SLICE_BEATS=4, default build).
module tb_dmac_chan_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmac_chan_sched_if #(.NUM_REQ(4)) bus ();

  dmac_chan_sched #(.NUM_REQ(4), .SLICE_BEATS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int pause_cnt = 0;
  int exp_pause = 0;

  // Expected grants: {Ch_Resume, Grant_Id, ReqAck}
  logic [6:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_grant(input logic resume, input logic [1:0] id);
    logic [3:0] one;
    one = 4'b0001;
    exp_q.push_back({resume, id, one << id});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus.Ch_Start === 1'b1) break;
      cyc(1);
    end
    chk(tag, 32'(bus.Ch_Start), 32'd1);
  endtask

  task automatic beat();
    bus.Beat_Done = 1'b1;
    cyc(1);
    bus.Beat_Done = 1'b0;
  endtask

  task automatic trans_done();
    bus.Trans_Done = 1'b1;
    cyc(1);
    bus.Trans_Done = 1'b0;
  endtask

  // Grant monitor: every start must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.Ch_Pause === 1'b1) pause_cnt++;
    if (bus.Ch_Start === 1'b1) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        chk("grant", 32'({bus.Ch_Resume, bus.Grant_Id, bus.ReqAck}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    bus.DmacReq    = '0;
    bus.Bus_Grant  = 1'b0;
    bus.HReady     = 1'b0;
    bus.Beat_Done  = 1'b0;
    bus.Trans_Done = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);

    // Reset state
    chk("rst_bus_req",   32'(bus.Bus_Req),   32'd0);
    chk("rst_grant_vld", 32'(bus.Grant_Vld), 32'd0);
    chk("rst_grant_id",  32'(bus.Grant_Id),  32'd0);
    chk("rst_req_ack",   32'(bus.ReqAck),    32'd0);
    chk("rst_pending",   32'(bus.Pending),   32'd0);
    chk("rst_start",     32'(bus.Ch_Start),  32'd0);

    // 1: single request, full handshake and release gap
    bus.Bus_Grant = 1'b1;
    bus.HReady    = 1'b1;
    bus.DmacReq   = 4'b0010;
    push_grant(1'b0, 2'd1);
    cyc(1);
    chk("t1_bus_req",   32'(bus.Bus_Req),   32'd1);
    chk("t1_no_vld",    32'(bus.Grant_Vld), 32'd0);
    cyc(1);
    chk("t1_start",     32'(bus.Ch_Start),  32'd1);
    chk("t1_start_vld", 32'(bus.Grant_Vld), 32'd1);
    bus.DmacReq = '0;
    cyc(1);
    chk("t1_active_vld", 32'(bus.Grant_Vld), 32'd1);
    chk("t1_active_id",  32'(bus.Grant_Id),  32'd1);
    chk("t1_active_req", 32'(bus.Bus_Req),   32'd1);
    trans_done();
    chk("t1_rel_req",  32'(bus.Bus_Req),   32'd0);
    chk("t1_rel_vld",  32'(bus.Grant_Vld), 32'd0);
    cyc(1);
    chk("t1_idle_req", 32'(bus.Bus_Req),   32'd0);
    cyc(2);
    chk("t1_idle2_req", 32'(bus.Bus_Req),  32'd0);

    // 2: simultaneous requests, highest index first
    bus.DmacReq = 4'b1001;
    push_grant(1'b0, 2'd3);
    wait_start("t2_start3");
    bus.DmacReq = 4'b0001;
    cyc(1);
    chk("t2_id3", 32'(bus.Grant_Id), 32'd3);
    push_grant(1'b0, 2'd0);
    trans_done();
    wait_start("t2_start0");
    bus.DmacReq = '0;
    cyc(1);
    chk("t2_id0", 32'(bus.Grant_Id), 32'd0);
    trans_done();
    cyc(2);

    // 3: slice expiry hands over to a waiting requester, then resume
    bus.DmacReq = 4'b0010;
    push_grant(1'b0, 2'd1);
    wait_start("t3_start1");
    bus.DmacReq = 4'b0100;
    push_grant(1'b0, 2'd2);
    push_grant(1'b1, 2'd1);
    cyc(1);
    beat();
    beat();
    beat();
    chk("t3_no_pause_yet", 32'(pause_cnt), 32'(exp_pause));
    bus.Beat_Done = 1'b1;
    #1;
    chk("t3_pause", 32'(bus.Ch_Pause), 32'd1);
    exp_pause++;
    cyc(1);
    bus.Beat_Done = 1'b0;
    chk("t3_pending", 32'(bus.Pending), 32'h2);
    chk("t3_rel_req", 32'(bus.Bus_Req), 32'd0);
    chk("t3_pause_cnt", 32'(pause_cnt), 32'(exp_pause));
    wait_start("t3_start2");
    bus.DmacReq = '0;
    cyc(1);
    chk("t3_id2", 32'(bus.Grant_Id), 32'd2);
    trans_done();
    wait_start("t3_resume1");
    cyc(1);
    chk("t3_pend_clr", 32'(bus.Pending), 32'd0);
    chk("t3_id1", 32'(bus.Grant_Id), 32'd1);
    trans_done();
    cyc(2);

    // 4: bus arbiter preemption keeps the same winner
    bus.DmacReq = 4'b1000;
    push_grant(1'b0, 2'd3);
    wait_start("t4_start3");
    bus.DmacReq = '0;
    cyc(1);
    beat();
    bus.Bus_Grant = 1'b0;
    #1;
    chk("t4_pause", 32'(bus.Ch_Pause), 32'd1);
    exp_pause++;
    push_grant(1'b1, 2'd3);
    cyc(1);
    chk("t4_bus_req", 32'(bus.Bus_Req),   32'd1);
    chk("t4_no_vld",  32'(bus.Grant_Vld), 32'd0);
    chk("t4_pending", 32'(bus.Pending),   32'h8);
    cyc(2);
    chk("t4_wait_req",   32'(bus.Bus_Req),  32'd1);
    chk("t4_wait_start", 32'(bus.Ch_Start), 32'd0);
    bus.Bus_Grant = 1'b1;
    wait_start("t4_resume3");
    cyc(1);
    chk("t4_id3",       32'(bus.Grant_Id), 32'd3);
    chk("t4_pend_clr",  32'(bus.Pending),  32'd0);
    chk("t4_pause_cnt", 32'(pause_cnt),    32'(exp_pause));
    trans_done();
    cyc(2);

    // 5: completion on the slice-expiring beat wins, no pause
    bus.DmacReq = 4'b0010;
    push_grant(1'b0, 2'd1);
    wait_start("t5_start1");
    bus.DmacReq = '0;
    cyc(1);
    beat();
    beat();
    beat();
    bus.DmacReq = 4'b0100;
    push_grant(1'b0, 2'd2);
    bus.Beat_Done  = 1'b1;
    bus.Trans_Done = 1'b1;
    #1;
    chk("t5_no_pause", 32'(bus.Ch_Pause), 32'd0);
    cyc(1);
    bus.Beat_Done  = 1'b0;
    bus.Trans_Done = 1'b0;
    chk("t5_pending",   32'(bus.Pending), 32'd0);
    chk("t5_pause_cnt", 32'(pause_cnt),   32'(exp_pause));
    wait_start("t5_start2");
    bus.DmacReq = '0;
    cyc(1);
    trans_done();
    cyc(2);

    // 6: reset in S_ACTIVE with a suspended transfer and a preempting arbiter
    bus.DmacReq = 4'b0010;
    push_grant(1'b0, 2'd1);
    wait_start("t6_start1");
    bus.DmacReq = 4'b0100;
    push_grant(1'b0, 2'd2);
    cyc(1);
    beat();
    beat();
    beat();
    beat();
    exp_pause++;
    wait_start("t6_start2");
    bus.DmacReq = '0;
    cyc(1);
    chk("t6_pend_pre", 32'(bus.Pending), 32'h2);
    rst           = 1'b1;
    bus.Bus_Grant = 1'b0;
    #1;
    chk("t6_rst_no_pause", 32'(bus.Ch_Pause), 32'd0);
    cyc(1);
    chk("t6_bus_req",   32'(bus.Bus_Req),   32'd0);
    chk("t6_grant_vld", 32'(bus.Grant_Vld), 32'd0);
    chk("t6_grant_id",  32'(bus.Grant_Id),  32'd0);
    chk("t6_pending",   32'(bus.Pending),   32'd0);
    chk("t6_state",     32'(bus.dbg_state), 32'd0);
    rst           = 1'b0;
    bus.Bus_Grant = 1'b1;
    cyc(2);
    chk("t6_idle_req",  32'(bus.Bus_Req), 32'd0);
    chk("t6_pause_cnt", 32'(pause_cnt),   32'(exp_pause));
    chk("sb_drained",   32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmac_chan_sched.md
Name: dmac_chan_sched

Overview:
- Channel scheduler in front of the DMAC main controller.
- Arbitrates NUM_REQ peripheral DMA requests and owns the bus request/grant handshake for the winner.
- Issues start/resume and pause strobes to the channel datapath.
- Time-slices long transfers so that no requester monopolises the AHB master port.

Parameters:
- NUM_REQ, 4, number of peripheral requesters (2..8).
- SLICE_BEATS, 16, completed beats allowed per grant before yielding to a waiting requester (1..255).
- ID_W, $clog2(NUM_REQ), width of Grant_Id.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- DmacReq  in  NUM_REQ  level requests from peripherals
- Bus_Grant  in  1  AHB bus arbiter grant
- HReady  in  1  AHB ready
- Beat_Done  in  1  active channel completed one data beat (single-cycle pulse)
- Trans_Done  in  1  active channel finished its whole transfer (single-cycle pulse)
- Bus_Req  out  1  bus request to the AHB arbiter
- Grant_Vld  out  1  a channel currently owns the master port
- Grant_Id  out  ID_W  index of the granted requester
- ReqAck  out  NUM_REQ  one-hot acknowledge pulse to the winning peripheral
- Ch_Start  out  1  one-cycle pulse: channel begins or resumes
- Ch_Resume  out  1  valid with Ch_Start; 1 means resume a suspended transfer, 0 means fresh start
- Ch_Pause  out  1  one-cycle pulse: channel must suspend after the current beat
- Pending  out  NUM_REQ  mask of suspended, partially complete transfers

Behaviour:
- Reset values: all outputs 0, FSM in S_IDLE, beat counter 0, Pending 0, winner register 0. A reset asserted mid-operation aborts immediately and no pause pulse is issued.
- Eligible mask = DmacReq | Pending.
- Winner selection is fixed priority: the highest eligible index wins.
- FSM states: S_IDLE, S_BUS_REQ, S_START, S_ACTIVE, S_RELEASE.
- S_IDLE:
  - If eligible != 0: latch the winner into the winner register and go to S_BUS_REQ. Bus_Req rises in the next cycle.
  - Otherwise remain in S_IDLE.
- S_BUS_REQ:
  - Bus_Req=1.
  - When Bus_Grant && HReady: go to S_START.
  - Otherwise wait indefinitely. The winner register is frozen, so newly arriving higher-priority requests do not re-arbitrate here.
- S_START (exactly 1 cycle):
  - Bus_Req=1, Grant_Vld=1.
  - ReqAck[winner]=1, Ch_Start=1, Ch_Resume=Pending[winner].
  - Clear Pending[winner] and the beat counter, then go to S_ACTIVE.
- S_ACTIVE:
  - Bus_Req=1, Grant_Vld=1, Grant_Id=winner.
  - Beat counter increments on Beat_Done and saturates at SLICE_BEATS.
  - Exit conditions, in priority order:
    1. Trans_Done: go to S_RELEASE; Pending[winner] stays 0.
    2. Bus_Grant==0 (bus arbiter preemption): Ch_Pause=1, set Pending[winner], go to S_BUS_REQ with the same winner. The winner is not re-arbitrated.
    3. Beat_Done, counter reaching SLICE_BEATS on this beat, and any other eligible bit set: Ch_Pause=1, set Pending[winner], go to S_RELEASE.
    4. Otherwise stay in S_ACTIVE.
  - If the slice expires with no other requester eligible, continue: the counter stays saturated and is re-evaluated on every Beat_Done.
  - Trans_Done and slice expiry in the same cycle: Trans_Done wins and no Ch_Pause is issued.
- S_RELEASE (exactly 1 cycle):
  - All outputs 0 except Pending. This gives the AHB arbiter one idle cycle without request.
  - Go to S_IDLE. Minimum gap from Trans_Done to the next Bus_Req is therefore 2 cycles.
- Grant_Id holds its last value while Grant_Vld=0. Output checks must consider it only when Grant_Vld=1.
- Beat_Done and Trans_Done are ignored outside S_ACTIVE.

Optional Feature:
- Macro DMAC_SCHED_RR_EN.
- When defined, winner selection is round-robin. A last-granted pointer (reset 0) is updated in S_START, and the search starts at pointer+1 modulo NUM_REQ.
- When undefined, fixed highest-index priority applies and the pointer logic is absent.
- Slice preemption behaves identically in both builds.

Test Plan:
1. DmacReq=4'b0010, Bus_Grant tied 1 -> Bus_Req at cycle 2; ReqAck=4'b0010, Ch_Start=1, Ch_Resume=0 in S_START; Trans_Done -> Bus_Req low 1 cycle later; idle afterwards.
2. DmacReq=4'b1001 together -> Grant_Id=3 first; after its Trans_Done, Grant_Id=0 (fixed). With DMAC_SCHED_RR_EN: DmacReq held at 4'b1001 -> alternates 3,0,3.
3. SLICE_BEATS=4, req 1 active, req 2 asserts, 4 Beat_Done pulses -> Ch_Pause on the 4th; Pending=4'b0010; req 2 granted with Ch_Resume=0; after its Trans_Done, req 1 granted with Ch_Resume=1.
4. Bus_Grant drops mid-S_ACTIVE -> Ch_Pause pulse, Pending[winner] set, Bus_Req stays 1; on re-grant, same Grant_Id with Ch_Resume=1.
5. Trans_Done and the 4th Beat_Done in the same cycle with another requester waiting -> no Ch_Pause; Pending unchanged.
6. rst asserted in S_ACTIVE -> next cycle all outputs 0 and Pending=0; no pause pulse.
